// File: rtl/trng_fifo_pkg.sv
// Shared constants and elaboration helpers for the parametrised TRNG/keystream FIFO.
package trng_fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH      = 64;

  // Occupancy needs one more bit than the pointers so that DEPTH itself is representable.
  function automatic int fifo_lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit fifo_params_ok(input int dw, input int depth, input int fwft,
                                        input int af, input int ae);
    return (dw >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (fwft == 0 || fwft == 1) &&
           (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/trng_fifo_flex_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read, no reset.
module fifo_mem_dp #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/trng_fifo_flex.sv
// Parametrised entropy/keystream FIFO: pointers, occupancy, threshold flags,
// sticky error flags, flush, and a registered or first-word-fall-through read port.
module trng_fifo_flex
  import trng_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = 56,
  parameter int AE_THRESH  = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          data_valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [fifo_lvl_w(DEPTH)-1:0]  level,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = fifo_lvl_w(DEPTH);

  if (!fifo_params_ok(DATA_WIDTH, DEPTH, FWFT, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $error("trng_fifo_flex: illegal parameter combination");
  end

  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  wr_acc, rd_acc;

  // Flags decode straight off the registered level, so they carry no extra latency.
  assign full         = (level == LW'(DEPTH));
  assign empty        = (level == '0);
  assign almost_full  = (level >= LW'(AF_THRESH));
  assign almost_empty = (level <= LW'(AE_THRESH));

  assign wr_acc = wr_en & ~full  & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  fifo_mem_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (wr_en & full)  overflow  <= 1'b1;
      if (rd_en & empty) underflow <= 1'b1;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is always on the bus; contents are don't-care while empty.
    assign data_out   = mem_rdata;
    assign data_valid = ~empty;
  end else begin : g_reg
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        data_out   <= '0;
        data_valid <= 1'b0;
      end else begin
        data_valid <= rd_acc;
        if (rd_acc) data_out <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_trng_fifo_flex.sv
// Randomised + directed bench: a registered-read 64x8 FIFO and an FWFT 4x16 FIFO against queue models.
module tb_trng_fifo_flex;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic       a_flush, a_wr, a_rd, a_dv, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [7:0] a_din, a_dout;
  logic [6:0] a_lvl;

  logic        b_flush, b_wr, b_rd, b_dv, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [15:0] b_din, b_dout;
  logic [2:0]  b_lvl;

  trng_fifo_flex #(.DATA_WIDTH(8), .DEPTH(64), .FWFT(0), .AF_THRESH(56), .AE_THRESH(8)) u_a (
    .clk(clk), .reset_n(reset_n), .flush(a_flush), .wr_en(a_wr), .data_in(a_din),
    .rd_en(a_rd), .data_out(a_dout), .data_valid(a_dv), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .level(a_lvl), .overflow(a_ovf), .underflow(a_unf));

  trng_fifo_flex #(.DATA_WIDTH(16), .DEPTH(4), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)) u_b (
    .clk(clk), .reset_n(reset_n), .flush(b_flush), .wr_en(b_wr), .data_in(b_din),
    .rd_en(b_rd), .data_out(b_dout), .data_valid(b_dv), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .level(b_lvl), .overflow(b_ovf), .underflow(b_unf));

  // Reference models: plain queues plus the few bits of visible state.
  logic [7:0]  qa[$];
  logic [15:0] qb[$];
  bit          ma_ovf, ma_unf, ma_dv, mb_ovf, mb_unf;
  logic [7:0]  ma_dout;
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    qa.delete(); qb.delete();
    ma_ovf = 0; ma_unf = 0; ma_dv = 0; ma_dout = '0;
    mb_ovf = 0; mb_unf = 0;
  endtask

  task automatic model_edge();
    bit f, e;
    if (a_flush) begin
      qa.delete(); ma_ovf = 0; ma_unf = 0; ma_dv = 0;
    end else begin
      f = (qa.size() == 64); e = (qa.size() == 0);
      if (a_wr && f) ma_ovf = 1;
      if (a_rd && e) ma_unf = 1;
      ma_dv = a_rd && !e;
      if (a_rd && !e) ma_dout = qa.pop_front();
      if (a_wr && !f) qa.push_back(a_din);
    end
    if (b_flush) begin
      qb.delete(); mb_ovf = 0; mb_unf = 0;
    end else begin
      f = (qb.size() == 4); e = (qb.size() == 0);
      if (b_wr && f) mb_ovf = 1;
      if (b_rd && e) mb_unf = 1;
      if (b_rd && !e) void'(qb.pop_front());
      if (b_wr && !f) qb.push_back(b_din);
    end
  endtask

  task automatic check_all();
    chk("a_level", 32'(a_lvl), 32'(qa.size()));
    chk("a_full", 32'(a_full), 32'(qa.size() == 64));
    chk("a_empty", 32'(a_empty), 32'(qa.size() == 0));
    chk("a_almost_full", 32'(a_af), 32'(qa.size() >= 56));
    chk("a_almost_empty", 32'(a_ae), 32'(qa.size() <= 8));
    chk("a_overflow", 32'(a_ovf), 32'(ma_ovf));
    chk("a_underflow", 32'(a_unf), 32'(ma_unf));
    chk("a_data_valid", 32'(a_dv), 32'(ma_dv));
    chk("a_data_out", 32'(a_dout), 32'(ma_dout));
    chk("b_level", 32'(b_lvl), 32'(qb.size()));
    chk("b_full", 32'(b_full), 32'(qb.size() == 4));
    chk("b_empty", 32'(b_empty), 32'(qb.size() == 0));
    chk("b_almost_full", 32'(b_af), 32'(qb.size() >= 3));
    chk("b_almost_empty", 32'(b_ae), 32'(qb.size() <= 1));
    chk("b_overflow", 32'(b_ovf), 32'(mb_ovf));
    chk("b_underflow", 32'(b_unf), 32'(mb_unf));
    chk("b_data_valid", 32'(b_dv), 32'(qb.size() != 0));
    if (qb.size() != 0) chk("b_data_out", 32'(b_dout), 32'(qb[0]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_b();
    b_flush = ($urandom_range(0, 59) == 0);
    b_wr    = $urandom_range(0, 1) != 0;
    b_rd    = $urandom_range(0, 1) != 0;
    b_din   = 16'($urandom);
  endtask

  task automatic cyc_a(input bit fl, input bit we, input bit re, input logic [7:0] din);
    a_flush = fl; a_wr = we; a_rd = re; a_din = din;
    rand_b();
    step();
  endtask

  task automatic cyc_b(input bit fl, input bit we, input bit re, input logic [15:0] din);
    a_flush = 0; a_wr = 0; a_rd = 0;
    b_flush = fl; b_wr = we; b_rd = re; b_din = din;
    step();
  endtask

  task automatic check_reset_values();
    chk("rst_a_level", 32'(a_lvl), 32'd0);
    chk("rst_a_empty", 32'(a_empty), 32'd1);
    chk("rst_a_almost_empty", 32'(a_ae), 32'd1);
    chk("rst_a_full", 32'(a_full), 32'd0);
    chk("rst_a_almost_full", 32'(a_af), 32'd0);
    chk("rst_a_data_out", 32'(a_dout), 32'd0);
    chk("rst_a_data_valid", 32'(a_dv), 32'd0);
    chk("rst_a_errors", 32'({a_ovf, a_unf}), 32'd0);
    chk("rst_b_level", 32'(b_lvl), 32'd0);
    chk("rst_b_data_valid", 32'(b_dv), 32'd0);
    chk("rst_b_errors", 32'({b_ovf, b_unf}), 32'd0);
  endtask

  initial begin
    int pw, pr;
    reset_n = 0;
    a_flush = 0; a_wr = 0; a_rd = 0; a_din = '0;
    b_flush = 0; b_wr = 0; b_rd = 0; b_din = '0;
    model_reset();
    #12;
    check_reset_values();
    @(negedge clk);
    reset_n = 1;

    // Fill, overflow, full simultaneous access, drain, underflow, flush.
    for (int i = 0; i < 64; i++) cyc_a(0, 1, 0, 8'(i));
    chk("fill_full", 32'(a_full), 32'd1);
    chk("fill_level", 32'(a_lvl), 32'd64);
    cyc_a(0, 1, 0, 8'hEE);
    chk("ovf_set", 32'(a_ovf), 32'd1);
    chk("ovf_level", 32'(a_lvl), 32'd64);
    cyc_a(0, 1, 1, 8'h77);
    chk("full_both_level", 32'(a_lvl), 32'd63);
    chk("full_both_data", 32'(a_dout), 32'h00);
    for (int i = 0; i < 63; i++) cyc_a(0, 0, 1, 8'h00);
    chk("drain_last", 32'(a_dout), 32'h3F);
    chk("drain_empty", 32'(a_empty), 32'd1);
    cyc_a(0, 0, 1, 8'h00);
    chk("unf_set", 32'(a_unf), 32'd1);
    chk("ovf_sticky", 32'(a_ovf), 32'd1);
    cyc_a(1, 0, 0, 8'h00);
    chk("flush_clears_errors", 32'({a_ovf, a_unf}), 32'd0);

    // Empty with both asserted.
    cyc_a(0, 1, 1, 8'hA5);
    chk("empty_both_level", 32'(a_lvl), 32'd1);
    chk("empty_both_unf", 32'(a_unf), 32'd1);
    cyc_a(1, 0, 0, 8'h00);

    // Level 10 with both asserted for 20 cycles.
    for (int i = 0; i < 10; i++) cyc_a(0, 1, 0, 8'($urandom));
    for (int i = 0; i < 20; i++) cyc_a(0, 1, 1, 8'($urandom));
    chk("mid_both_level", 32'(a_lvl), 32'd10);
    for (int i = 0; i < 10; i++) cyc_a(0, 0, 1, 8'h00);

    // Flush with a concurrent write at level 5.
    for (int i = 0; i < 5; i++) cyc_a(0, 1, 0, 8'(8'h50 + i));
    cyc_a(1, 1, 0, 8'h99);
    chk("flush_wr_level", 32'(a_lvl), 32'd0);
    chk("flush_wr_empty", 32'(a_empty), 32'd1);
    chk("flush_wr_no_ovf", 32'(a_ovf), 32'd0);
    cyc_a(0, 0, 0, 8'h00);

    // FWFT instance directed checks.
    cyc_b(1, 0, 0, 16'h0);
    cyc_b(0, 1, 0, 16'h1234);
    chk("fwft_first_valid", 32'(b_dv), 32'd1);
    chk("fwft_first_data", 32'(b_dout), 32'h1234);
    cyc_b(0, 1, 0, 16'h5678);
    cyc_b(0, 0, 1, 16'h0);
    chk("fwft_pop_next", 32'(b_dout), 32'h5678);
    cyc_b(0, 0, 1, 16'h0);
    for (int i = 0; i < 10; i++) begin
      cyc_b(0, 1, 0, 16'(16'hC000 + i * 16'h0101));
      cyc_b(0, 0, 1, 16'h0);
    end
    chk("fwft_wrap_empty", 32'(b_empty), 32'd1);

    // Random traffic with drifting write/read bias so both ends of the range get hit.
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) begin
        pw = $urandom_range(10, 95);
        pr = $urandom_range(10, 95);
      end
      a_flush = ($urandom_range(0, 299) == 0);
      a_wr    = $urandom_range(0, 99) < pw;
      a_rd    = $urandom_range(0, 99) < pr;
      a_din   = 8'($urandom);
      rand_b();
      step();
    end

    // Asynchronous reset in the middle of a write burst.
    for (int i = 0; i < 20; i++) cyc_a(0, 1, 0, 8'($urandom));
    #2;
    reset_n = 0;
    #1;
    model_reset();
    check_reset_values();
    @(negedge clk);
    check_reset_values();
    a_wr = 0; b_wr = 0; b_rd = 0; b_flush = 0;
    reset_n = 1;
    for (int n = 0; n < 300; n++) begin
      a_flush = 0;
      a_wr    = $urandom_range(0, 99) < 60;
      a_rd    = $urandom_range(0, 99) < 50;
      a_din   = 8'($urandom);
      rand_b();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
